// File: rtl/l2_cache_controller.sv
`timescale 1ns/1ps
// l2_cache_controller: sequences lookup, bus traffic and write-back of one set per command; STATS_EN adds counters.
// Latency: 4 cycles from accept to cmd_done for a hit with no bus work; clear takes 2^indexBits+1.
// Backpressure: one command in flight (cmd_ready low until cmd_done); bus states stall until bus_ack.
module l2_cache_controller #(
  parameter int indexBits = 14,
  parameter int tagBits   = 12,
  parameter int ways      = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    command,
  input  logic [tagBits+indexBits-1:0]  address,
  output logic                          cmd_done,
  output logic                          hit,
  output logic                          ds_rd_en,
  output logic [indexBits-1:0]          ds_index,
  input  logic [ways*tagBits-1:0]       ds_tags,
  input  logic [ways*2-1:0]             ds_mesi,
  input  logic [ways-2:0]               ds_plru,
  output logic                          ds_wr_en,
  output logic [$clog2(ways)-1:0]       ds_wr_way,
  output logic [tagBits-1:0]            ds_wr_tag,
  output logic [1:0]                    ds_wr_mesi,
  output logic [ways-2:0]               ds_wr_plru,
  output logic                          ds_clr_en,
  output logic                          bus_req,
  output logic [2:0]                    bus_op,
  output logic [tagBits+indexBits-1:0]  bus_addr,
  input  logic                          bus_ack,
  input  logic [1:0]                    bus_snoop,
  output logic                          snoop_resp_valid,
  output logic [1:0]                    snoop_resp
`ifdef STATS_EN
  ,
  output logic [31:0]                   stat_reads,
  output logic [31:0]                   stat_writes,
  output logic [31:0]                   stat_hits,
  output logic [31:0]                   stat_misses
`endif
);

  localparam int WW = $clog2(ways);
  localparam int AW = tagBits + indexBits;

  localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
  localparam logic [2:0] OP_READ = 3'd1, OP_WRITE = 3'd2, OP_INV = 3'd3, OP_RWIM = 3'd4;
  localparam logic [1:0] RESP_NOHIT = 2'd0, RESP_HIT = 2'd1, RESP_HITM = 2'd2;

  typedef enum logic [2:0] {
    st_idle, st_lookup, st_compare, st_wb, st_bus, st_update, st_clear, st_done
  } state_t;

  state_t state, nxt;

  logic [3:0]           cmd_q;
  logic [AW-1:0]        addr_q;
  logic [WW-1:0]        way_q;
  logic [1:0]           mesi_q;
  logic [ways-2:0]      plru_q;
  logic [tagBits-1:0]   wbtag_q;
  logic [2:0]           op_q;
  logic                 wb_bus_q;
  logic                 hit_q;
  logic                 gap_q;
  logic [indexBits-1:0] clr_idx_q;

  logic [tagBits-1:0]   addr_tag;
  logic [indexBits-1:0] addr_idx;
  logic                 bus_live;
  logic                 is_l1;

  assign addr_tag = addr_q[AW-1 -: tagBits];
  assign addr_idx = addr_q[indexBits-1:0];
  assign is_l1    = (cmd_q <= 4'd2);
  // gap_q forces one idle bus cycle between a writeback ack and the follow-on request
  assign bus_live = ((state == st_wb) || (state == st_bus)) && !gap_q;

  function automatic logic [WW-1:0] plru_victim(input logic [ways-2:0] p);
    logic [WW-1:0] node;
    logic [WW-1:0] v;
    node = '0;
    v    = '0;
    for (int l = 0; l < WW; l++) begin
      v[WW-1-l] = p[node];
      node = WW'(2 * int'(node) + 1 + int'(p[node]));
    end
    return v;
  endfunction

  function automatic logic [ways-2:0] plru_touch(input logic [ways-2:0] p, input logic [WW-1:0] w);
    logic [ways-2:0] r;
    logic [WW-1:0]   node;
    r    = p;
    node = '0;
    for (int l = 0; l < WW; l++) begin
      r[node] = ~w[WW-1-l];
      node = WW'(2 * int'(node) + 1 + int'(w[WW-1-l]));
    end
    return r;
  endfunction

  // Set lookup: lowest matching valid way, lowest invalid way, victim selection
  logic               lk_hit, lk_inv;
  logic [WW-1:0]      lk_hit_way, lk_inv_way, vic;
  logic [1:0]         hit_mesi, vic_mesi;
  logic [tagBits-1:0] vic_tag;

  always_comb begin
    lk_hit     = 1'b0;
    lk_inv     = 1'b0;
    lk_hit_way = '0;
    lk_inv_way = '0;
    for (int w = ways-1; w >= 0; w--) begin
      if (ds_mesi[2*w +: 2] != MESI_I && ds_tags[w*tagBits +: tagBits] == addr_tag) begin
        lk_hit     = 1'b1;
        lk_hit_way = WW'(w);
      end
      if (ds_mesi[2*w +: 2] == MESI_I) begin
        lk_inv     = 1'b1;
        lk_inv_way = WW'(w);
      end
    end
    vic      = lk_inv ? lk_inv_way : plru_victim(ds_plru);
    hit_mesi = MESI_I;
    vic_mesi = MESI_I;
    vic_tag  = '0;
    for (int w = 0; w < ways; w++) begin
      if (WW'(w) == lk_hit_way) hit_mesi = ds_mesi[2*w +: 2];
      if (WW'(w) == vic) begin
        vic_mesi = ds_mesi[2*w +: 2];
        vic_tag  = ds_tags[w*tagBits +: tagBits];
      end
    end
  end

  state_t             pl_nxt;
  logic [WW-1:0]      pl_way;
  logic [1:0]         pl_mesi, pl_resp;
  logic [ways-2:0]    pl_plru;
  logic [tagBits-1:0] pl_wbtag;
  logic [2:0]         pl_op;
  logic               pl_wb_bus;

  always_comb begin
    pl_nxt    = st_done;
    pl_way    = lk_hit ? lk_hit_way : vic;
    pl_mesi   = hit_mesi;
    pl_resp   = RESP_NOHIT;
    pl_plru   = is_l1 ? plru_touch(ds_plru, pl_way) : ds_plru;
    pl_wbtag  = lk_hit ? addr_tag : vic_tag;
    pl_op     = OP_READ;
    pl_wb_bus = 1'b0;
    case (cmd_q)
      4'd0, 4'd2: begin
        if (lk_hit) pl_nxt = st_update;
        else begin
          pl_mesi   = MESI_E;
          pl_wb_bus = 1'b1;
          pl_nxt    = (vic_mesi == MESI_M) ? st_wb : st_bus;
        end
      end
      4'd1: begin
        pl_mesi = MESI_M;
        if (lk_hit) begin
          pl_op  = OP_INV;
          pl_nxt = (hit_mesi == MESI_S) ? st_bus : st_update;
        end else begin
          pl_op     = OP_RWIM;
          pl_wb_bus = 1'b1;
          pl_nxt    = (vic_mesi == MESI_M) ? st_wb : st_bus;
        end
      end
      4'd3: if (lk_hit) begin
        pl_resp = RESP_HIT;
        pl_mesi = MESI_I;
        pl_nxt  = st_update;
      end
      4'd4, 4'd6: if (lk_hit) begin
        pl_resp = (hit_mesi == MESI_M) ? RESP_HITM : RESP_HIT;
        pl_mesi = (cmd_q == 4'd4) ? MESI_S : MESI_I;
        pl_nxt  = (hit_mesi == MESI_M) ? st_wb : st_update;
      end
      default: pl_nxt = st_done;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= st_idle;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      st_idle: if (cmd_valid) begin
        if (command == 4'd8)      nxt = st_clear;
        else if (command <= 4'd6) nxt = st_lookup;
        else                      nxt = st_done;
      end
      st_lookup:  nxt = st_compare;
      st_compare: nxt = pl_nxt;
      st_wb:      if (bus_live && bus_ack) nxt = wb_bus_q ? st_bus : st_update;
      st_bus:     if (bus_live && bus_ack) nxt = st_update;
      st_update:  nxt = st_done;
      st_clear:   if (clr_idx_q == '1) nxt = st_done;
      st_done:    nxt = st_idle;
      default:    nxt = st_idle;
    endcase
  end

  always_comb begin
    cmd_ready        = (state == st_idle);
    cmd_done         = (state == st_done);
    hit              = (state == st_done) && hit_q;
    ds_rd_en         = (state == st_lookup);
    ds_clr_en        = (state == st_clear);
    ds_index         = (state == st_clear) ? clr_idx_q : (state == st_idle) ? '0 : addr_idx;
    ds_wr_en         = (state == st_update);
    ds_wr_way        = ds_wr_en ? way_q   : '0;
    ds_wr_tag        = ds_wr_en ? addr_tag : '0;
    ds_wr_mesi       = ds_wr_en ? mesi_q  : MESI_I;
    ds_wr_plru       = ds_wr_en ? plru_q  : '0;
    bus_req          = bus_live;
    bus_op           = 3'd0;
    bus_addr         = '0;
    if (bus_live) begin
      bus_op   = (state == st_wb) ? OP_WRITE : op_q;
      bus_addr = (state == st_wb) ? {wbtag_q, addr_idx} : addr_q;
    end
    snoop_resp_valid = (state == st_compare) && (cmd_q >= 4'd3) && (cmd_q <= 4'd6);
    snoop_resp       = snoop_resp_valid ? pl_resp : RESP_NOHIT;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cmd_q     <= '0;
      addr_q    <= '0;
      way_q     <= '0;
      mesi_q    <= MESI_I;
      plru_q    <= '0;
      wbtag_q   <= '0;
      op_q      <= OP_READ;
      wb_bus_q  <= 1'b0;
      hit_q     <= 1'b0;
      gap_q     <= 1'b0;
      clr_idx_q <= '0;
    end else begin
      gap_q <= (state == st_wb) && bus_live && bus_ack;
      if (state == st_idle && cmd_valid) begin
        cmd_q     <= command;
        addr_q    <= address;
        hit_q     <= 1'b0;
        clr_idx_q <= '0;
      end
      if (state == st_compare) begin
        way_q    <= pl_way;
        mesi_q   <= pl_mesi;
        plru_q   <= pl_plru;
        wbtag_q  <= pl_wbtag;
        op_q     <= pl_op;
        wb_bus_q <= pl_wb_bus;
        hit_q    <= lk_hit;
      end
      // fill state depends on whether another cache reported the line
      if (state == st_bus && bus_live && bus_ack && op_q == OP_READ)
        mesi_q <= (bus_snoop == RESP_HIT || bus_snoop == RESP_HITM) ? MESI_S : MESI_E;
      if (state == st_clear) clr_idx_q <= clr_idx_q + 1'b1;
    end
  end

`ifdef STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n || (state == st_done && cmd_q == 4'd8)) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == st_done && is_l1) begin
      if (cmd_q == 4'd1) stat_writes <= sat_inc(stat_writes);
      else               stat_reads  <= sat_inc(stat_reads);
      if (hit_q)         stat_hits   <= sat_inc(stat_hits);
      else               stat_misses <= sat_inc(stat_misses);
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache_controller.sv
`timescale 1ns/1ps
// Directed bench for l2_cache_controller with a small 16-set store model and a bus responder.
module tb_l2_cache_controller;
  localparam int IB = 4, TB = 12, W = 8, AW = TB + IB;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n, cmd_valid, cmd_ready, cmd_done, hit;
  logic [3:0]    command;
  logic [AW-1:0] address;
  logic          ds_rd_en, ds_wr_en, ds_clr_en;
  logic [IB-1:0] ds_index;
  logic [W*TB-1:0] ds_tags = '0;
  logic [W*2-1:0]  ds_mesi = '0;
  logic [W-2:0]    ds_plru = '0;
  logic [2:0]    ds_wr_way;
  logic [TB-1:0] ds_wr_tag;
  logic [1:0]    ds_wr_mesi;
  logic [W-2:0]  ds_wr_plru;
  logic          bus_req;
  logic [2:0]    bus_op;
  logic [AW-1:0] bus_addr;
  logic          bus_ack = 1'b0;
  logic [1:0]    bus_snoop = 2'd0;
  logic          snoop_resp_valid;
  logic [1:0]    snoop_resp;

  l2_cache_controller #(.indexBits(IB), .tagBits(TB), .ways(W)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .command(command), .address(address), .cmd_done(cmd_done), .hit(hit),
    .ds_rd_en(ds_rd_en), .ds_index(ds_index), .ds_tags(ds_tags), .ds_mesi(ds_mesi),
    .ds_plru(ds_plru), .ds_wr_en(ds_wr_en), .ds_wr_way(ds_wr_way), .ds_wr_tag(ds_wr_tag),
    .ds_wr_mesi(ds_wr_mesi), .ds_wr_plru(ds_wr_plru), .ds_clr_en(ds_clr_en),
    .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr), .bus_ack(bus_ack),
    .bus_snoop(bus_snoop), .snoop_resp_valid(snoop_resp_valid), .snoop_resp(snoop_resp)
  );

  // Store model: registered read data, write/clear logging
  logic [TB-1:0] st_tag  [16][8];
  logic [1:0]    st_mesi [16][8];
  logic [W-2:0]  st_plru [16];
  int            wr_cnt = 0, clr_cnt = 0, clr_bad = 0, sr_cnt = 0, req_cycles = 0;
  logic [3:0]    clr_next = '0;
  logic [2:0]    lw_way = '0;
  logic [TB-1:0] lw_tag = '0;
  logic [1:0]    lw_mesi = '0, sr_last = '0;
  logic [W-2:0]  lw_plru = '0;

  always @(posedge clock) begin
    if (ds_rd_en) begin
      for (int w = 0; w < W; w++) begin
        ds_tags[w*TB +: TB] <= st_tag[ds_index][w];
        ds_mesi[2*w +: 2]   <= st_mesi[ds_index][w];
      end
      ds_plru <= st_plru[ds_index];
    end
    if (ds_wr_en) begin
      st_tag[ds_index][ds_wr_way]  <= ds_wr_tag;
      st_mesi[ds_index][ds_wr_way] <= ds_wr_mesi;
      st_plru[ds_index]            <= ds_wr_plru;
      wr_cnt  <= wr_cnt + 1;
      lw_way  <= ds_wr_way;
      lw_tag  <= ds_wr_tag;
      lw_mesi <= ds_wr_mesi;
      lw_plru <= ds_wr_plru;
    end
    if (ds_clr_en) begin
      for (int w = 0; w < W; w++) st_mesi[ds_index][w] <= 2'd0;
      st_plru[ds_index] <= '0;
      clr_cnt <= clr_cnt + 1;
      if (ds_index != clr_next) clr_bad <= clr_bad + 1;
      clr_next <= ds_index + 4'd1;
    end
    if (snoop_resp_valid) begin
      sr_cnt  <= sr_cnt + 1;
      sr_last <= snoop_resp;
    end
  end

  // Bus responder: acks each request after three cycles unless held off
  logic          bus_hold = 1'b0;
  logic [1:0]    snoop_val = 2'd0;
  int            bcnt = 0;
  logic [2:0]    bl_op[$];
  logic [AW-1:0] bl_addr[$];

  always @(posedge clock) begin
    bus_ack <= 1'b0;
    if (bus_req) req_cycles <= req_cycles + 1;
    if (bus_req && !bus_ack && !bus_hold) begin
      if (bcnt == 2) begin
        bus_ack   <= 1'b1;
        bus_snoop <= snoop_val;
        bl_op.push_back(bus_op);
        bl_addr.push_back(bus_addr);
        bcnt <= 0;
      end else bcnt <= bcnt + 1;
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] op_at(input int i);
    return (bl_op.size() > i) ? 32'(bl_op[i]) : 32'hdead;
  endfunction

  function automatic logic [31:0] addr_at(input int i);
    return (bl_addr.size() > i) ? 32'(bl_addr[i]) : 32'hdead;
  endfunction

  task automatic run_cmd(input logic [3:0] c, input logic [AW-1:0] a, output int lat, output logic h);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clock); n++; end
    command   = c;
    address   = a;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    lat = 1;
    while (!cmd_done && lat < 300) begin @(negedge clock); lat++; end
    check("cmd_done_seen", 32'(cmd_done), 1);
    h = hit;
  endtask

  int   lat, nb, w0, r0, c0, b0, s0;
  logic h;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; command = 4'd0; address = '0;
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_outputs", {26'd0, cmd_done, hit, ds_wr_en, ds_clr_en, bus_req, snoop_resp_valid}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Clear-all: 16 consecutive sets then done
    c0 = clr_cnt; b0 = clr_bad;
    run_cmd(4'd8, '0, lat, h);
    check("clr_sets", 32'(clr_cnt - c0), 16);
    check("clr_order", 32'(clr_bad - b0), 0);
    check("clr_latency", 32'(lat), 17);

    // Cold read miss: READ, way 0 filled E
    snoop_val = 2'd0; nb = bl_op.size(); w0 = wr_cnt;
    run_cmd(4'd0, 16'h1234, lat, h);
    check("t1_nbus", 32'(bl_op.size() - nb), 1);
    check("t1_op", op_at(nb), 1);
    check("t1_addr", addr_at(nb), 32'h1234);
    check("t1_wr", 32'(wr_cnt - w0), 1);
    check("t1_way", 32'(lw_way), 0);
    check("t1_tag", 32'(lw_tag), 32'h123);
    check("t1_mesi", 32'(lw_mesi), 2);
    check("t1_plru", 32'(lw_plru), 32'h0B);
    check("t1_hit", 32'(h), 0);

    // Repeat read: hit, no bus, minimum latency
    r0 = req_cycles;
    run_cmd(4'd0, 16'h1234, lat, h);
    check("t2_bus_idle", 32'(req_cycles - r0), 0);
    check("t2_hit", 32'(h), 1);
    check("t2_latency", 32'(lat), 4);
    check("t2_mesi", 32'(lw_mesi), 2);

    // Instr read with shared snoop -> S, then write upgrade via INVALIDATE
    snoop_val = 2'd1; nb = bl_op.size();
    run_cmd(4'd2, 16'h4564, lat, h);
    check("t3a_addr", addr_at(nb), 32'h4564);
    check("t3a_way", 32'(lw_way), 1);
    check("t3a_mesi", 32'(lw_mesi), 1);
    check("t3a_plru", 32'(lw_plru), 32'h03);
    snoop_val = 2'd0; nb = bl_op.size();
    run_cmd(4'd1, 16'h4564, lat, h);
    check("t3b_nbus", 32'(bl_op.size() - nb), 1);
    check("t3b_op", op_at(nb), 3);
    check("t3b_addr", addr_at(nb), 32'h4564);
    check("t3b_mesi", 32'(lw_mesi), 3);
    check("t3b_way", 32'(lw_way), 1);
    check("t3b_hit", 32'(h), 1);

    // Fill index 5 with M lines via write misses (RWIM)
    for (int k = 0; k < 8; k++) begin
      nb = bl_op.size();
      run_cmd(4'd1, {12'hA00 + 12'(k), 4'h5}, lat, h);
      check("t4_fill_op", op_at(nb), 4);
      check("t4_fill_way", 32'(lw_way), 32'(k));
    end
    // PLRU all-zero after in-order fill: victim way 0 written back
    nb = bl_op.size();
    run_cmd(4'd0, 16'hB005, lat, h);
    check("t4a_nbus", 32'(bl_op.size() - nb), 2);
    check("t4a_wb_op", op_at(nb), 2);
    check("t4a_wb_addr", addr_at(nb), 32'hA005);
    check("t4a_rd_op", op_at(nb + 1), 1);
    check("t4a_rd_addr", addr_at(nb + 1), 32'hB005);
    check("t4a_way", 32'(lw_way), 0);
    check("t4a_mesi", 32'(lw_mesi), 2);
    check("t4a_plru", 32'(lw_plru), 32'h0B);
    check("t4a_hit", 32'(h), 0);
    // PLRU 0x0B now points at way 4
    nb = bl_op.size();
    run_cmd(4'd0, 16'hB015, lat, h);
    check("t4b_wb_addr", addr_at(nb), 32'hA045);
    check("t4b_rd_addr", addr_at(nb + 1), 32'hB015);
    check("t4b_way", 32'(lw_way), 4);
    check("t4b_plru", 32'(lw_plru), 32'h2E);

    // Snoop read of M line: HITM, writeback, becomes S, PLRU untouched
    nb = bl_op.size(); s0 = sr_cnt;
    run_cmd(4'd4, 16'hA015, lat, h);
    check("t5a_resp_cnt", 32'(sr_cnt - s0), 1);
    check("t5a_resp", 32'(sr_last), 2);
    check("t5a_op", op_at(nb), 2);
    check("t5a_addr", addr_at(nb), 32'hA015);
    check("t5a_way", 32'(lw_way), 1);
    check("t5a_mesi", 32'(lw_mesi), 1);
    check("t5a_plru", 32'(lw_plru), 32'h2E);
    check("t5a_hit", 32'(h), 1);
    // Snoop read of absent line: NOHIT, no bus, no write
    r0 = req_cycles; w0 = wr_cnt; s0 = sr_cnt;
    run_cmd(4'd4, 16'hCCC5, lat, h);
    check("t5b_resp_cnt", 32'(sr_cnt - s0), 1);
    check("t5b_resp", 32'(sr_last), 0);
    check("t5b_bus_idle", 32'(req_cycles - r0), 0);
    check("t5b_wr", 32'(wr_cnt - w0), 0);
    check("t5b_hit", 32'(h), 0);

    // Unknown command: immediate done, no store activity
    w0 = wr_cnt;
    run_cmd(4'd7, 16'h1234, lat, h);
    check("t6_latency", 32'(lat), 1);
    check("t6_hit", 32'(h), 0);
    check("t6_wr", 32'(wr_cnt - w0), 0);

    // Clear again, then previously held line misses
    c0 = clr_cnt; b0 = clr_bad;
    run_cmd(4'd8, '0, lat, h);
    check("t7_clr_sets", 32'(clr_cnt - c0), 16);
    check("t7_clr_order", 32'(clr_bad - b0), 0);
    nb = bl_op.size();
    run_cmd(4'd0, 16'h1234, lat, h);
    check("t7_miss", 32'(h), 0);
    check("t7_nbus", 32'(bl_op.size() - nb), 1);

    // Reset in the middle of a bus transaction
    bus_hold = 1'b1; w0 = wr_cnt;
    @(negedge clock);
    command = 4'd0; address = 16'h7777; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int n = 0; n < 50 && !bus_req; n++) @(negedge clock);
    check("t8_req_seen", 32'(bus_req), 1);
    reset_n = 1'b0;
    @(negedge clock);
    check("t8_req_drop", 32'(bus_req), 0);
    check("t8_ready", 32'(cmd_ready), 1);
    reset_n = 1'b1; bus_hold = 1'b0;
    repeat (4) @(negedge clock);
    check("t8_no_write", 32'(wr_cnt - w0), 0);
    check("t8_idle_bus", 32'(bus_req), 0);
    nb = bl_op.size();
    run_cmd(4'd0, 16'h7777, lat, h);
    check("t8_recover_addr", addr_at(nb), 32'h7777);
    check("t8_recover_hit", 32'(h), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
